// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the timer request arbiter.
package timer_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Pointer is sized for the largest supported client count so one type fits every build.
  localparam int unsigned N_REQ_MAX = 16;
  localparam int unsigned RR_PTR_W  = $clog2(N_REQ_MAX);

  function automatic logic [RR_PTR_W-1:0] onehot2idx(input logic [N_REQ_MAX-1:0] oh);
    logic [RR_PTR_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(N_REQ_MAX); i++) begin
      if (oh[i]) idx = idx | RR_PTR_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping at N_REQ.
module rr_picker
  import timer_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]    i_req,
  input  logic [RR_PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0]    o_gnt,
  output logic [RR_PTR_W-1:0] o_idx,
  output logic                o_valid
);

  int w_k;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_k     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= N_REQ) w_k = w_k - N_REQ;
      for (int j = 0; j < N_REQ; j++) begin
        if (!o_valid && (j == w_k) && i_req[j]) begin
          o_valid  = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = RR_PTR_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/timer_req_arbiter.sv
// Round-robin arbiter sharing one microsecond timer among N_REQ clients.
// Optional watchdog abort of a stuck WAIT is compiled in with TMR_ARB_WDOG_EN.
module timer_req_arbiter
  import timer_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int US_W        = 32,
  parameter int WDOG_CYCLES = 2**24
) (
  input  logic                  I_Clk,
  input  logic                  I_rst,
  input  logic [N_REQ-1:0]      I_req,
  input  logic [N_REQ*US_W-1:0] I_wait_us,
  output logic [N_REQ-1:0]      O_ack,
  output logic [N_REQ-1:0]      O_done,
  output logic [N_REQ-1:0]      O_grant,
  output logic                  O_busy,
  output logic                  O_err,
  output logic [US_W-1:0]       O_tmr_us,
  output logic                  O_tmr_req,
  input  logic                  I_tmr_ack,
  input  logic                  I_tmr_done,
  output state_t                O_dbg_state
);

  // Handshakes: a client holds I_req (and its delay) until the cycle O_ack[k] is high;
  // toward the timer O_tmr_req/O_tmr_us are held until the cycle I_tmr_ack is high,
  // and the transfer happens in that cycle. O_ack/O_done/O_err are 1-cycle pulses.

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic [RR_PTR_W-1:0] r_ptr;
  logic [US_W-1:0]     r_tmr_us;
  logic                r_tmr_req;
  logic                r_zero;

  logic [N_REQ-1:0]    w_pick_gnt;
  logic [RR_PTR_W-1:0] w_pick_idx;
  logic                w_pick_valid;
  logic [US_W-1:0]     w_pick_us;
  logic [RR_PTR_W-1:0] w_g_idx;
  logic [RR_PTR_W-1:0] w_next_ptr;

  if (N_REQ < 2 || N_REQ > int'(N_REQ_MAX) || WDOG_CYCLES < 1) begin : g_bad_param
    $error("timer_req_arbiter: parameter out of range");
  end

  rr_picker #(.N_REQ(N_REQ)) u_picker (
    .i_req   (I_req),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_pick_us  = US_W'(I_wait_us >> (int'(w_pick_idx) * US_W));
  assign w_g_idx    = onehot2idx(N_REQ_MAX'(r_grant));
  assign w_next_ptr = (w_g_idx == RR_PTR_W'(N_REQ - 1)) ? '0 : w_g_idx + RR_PTR_W'(1);

`ifdef TMR_ARB_WDOG_EN
  localparam logic [31:0] WDOG_LAST = 32'(WDOG_CYCLES - 1);
  logic [31:0] r_wdog_cnt;
  logic        r_err;
`endif

  always_ff @(posedge I_Clk or posedge I_rst) begin
    if (I_rst) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_ptr     <= '0;
      r_tmr_us  <= '0;
      r_tmr_req <= 1'b0;
      r_zero    <= 1'b0;
`ifdef TMR_ARB_WDOG_EN
      r_wdog_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
`ifdef TMR_ARB_WDOG_EN
      r_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_pick_valid) begin
            r_grant  <= w_pick_gnt;
            r_tmr_us <= w_pick_us;
            // A zero delay never touches the timer; RESP spends one extra cycle on the ack.
            if (w_pick_us == '0) begin
              r_zero  <= 1'b1;
              r_state <= RESP;
            end else begin
              r_tmr_req <= 1'b1;
              r_state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (I_tmr_ack) begin
            r_tmr_req <= 1'b0;
            r_state   <= I_tmr_done ? RESP : WAIT;
`ifdef TMR_ARB_WDOG_EN
            r_wdog_cnt <= '0;
`endif
          end
        end
        WAIT: begin
          if (I_tmr_done) begin
            r_state <= RESP;
          end
`ifdef TMR_ARB_WDOG_EN
          else if (r_wdog_cnt == WDOG_LAST) begin
            r_err   <= 1'b1;
            r_state <= RESP;
          end else begin
            r_wdog_cnt <= r_wdog_cnt + 32'd1;
          end
`endif
        end
        RESP: begin
          if (r_zero) begin
            r_zero <= 1'b0;
          end else begin
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign O_ack       = r_grant & {N_REQ{((r_state == ISSUE) && I_tmr_ack) || ((r_state == RESP) && r_zero)}};
  assign O_done      = r_grant & {N_REQ{(r_state == RESP) && !r_zero}};
  assign O_grant     = r_grant;
  assign O_busy      = (r_state != IDLE);
  assign O_tmr_us    = r_tmr_us;
  assign O_tmr_req   = r_tmr_req;
  assign O_dbg_state = r_state;

`ifdef TMR_ARB_WDOG_EN
  assign O_err = r_err;
`else
  assign O_err = 1'b0;
`endif

endmodule

// File: tb/tb_timer_req_arbiter.sv
// Directed bench for timer_req_arbiter with a behavioural microsecond timer model.
module tb_timer_req_arbiter;
  import timer_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int CLK_FRE = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] wait_us = '0;
  logic [N-1:0] ack, done, grant;
  logic         busy, err, tmr_req, tmr_ack, tmr_done;
  logic [W-1:0] tmr_us;
  state_t       dbg_state;

  // Timer model (auto) or direct drive from tasks (manual)
  logic tmr_mode = 1'b0;
  logic t_ack = 1'b0, t_done = 1'b0;
  logic m_ack = 1'b0, m_done = 1'b0, m_busy = 1'b0;
  int   m_cnt = 0;

  assign tmr_ack  = tmr_mode ? t_ack  : m_ack;
  assign tmr_done = tmr_mode ? t_done : m_done;

  int n_checks = 0;
  int n_fail = 0;

  logic [1:0] exp_q[$];
  logic [1:0] obs_ack_q[$];
  logic [1:0] obs_done_q[$];
  logic tmr_req_seen = 1'b0;
  logic multi_hot = 1'b0;
  int   err_cnt = 0;

  timer_req_arbiter #(.N_REQ(N), .US_W(W), .WDOG_CYCLES(100)) dut (
    .I_Clk       (clk),
    .I_rst       (rst),
    .I_req       (req),
    .I_wait_us   (wait_us),
    .O_ack       (ack),
    .O_done      (done),
    .O_grant     (grant),
    .O_busy      (busy),
    .O_err       (err),
    .O_tmr_us    (tmr_us),
    .O_tmr_req   (tmr_req),
    .I_tmr_ack   (tmr_ack),
    .I_tmr_done  (tmr_done),
    .O_dbg_state (dbg_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "time limit");
  end

  // Timer model: acks a pending request, then fires done after tmr_us*CLK_FRE cycles.
  // It ignores reset, like the real timer which is not aborted.
  always @(posedge clk) begin
    #2;
    m_ack  = 1'b0;
    m_done = 1'b0;
    if (m_busy) begin
      if (m_cnt <= 1) begin
        m_done = 1'b1;
        m_busy = 1'b0;
      end else begin
        m_cnt = m_cnt - 1;
      end
    end else if (tmr_req && !tmr_mode) begin
      m_ack  = 1'b1;
      m_busy = 1'b1;
      m_cnt  = int'(tmr_us) * CLK_FRE;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (ack[k])  obs_ack_q.push_back(2'(k));
        if (done[k]) obs_done_q.push_back(2'(k));
      end
      if (tmr_req) tmr_req_seen = 1'b1;
      if ($countones(ack) > 1 || $countones(done) > 1 || $countones(grant) > 1) multi_hot = 1'b1;
      if (err) err_cnt++;
    end
  end

  task automatic pulse_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    wait_us = '0;
    repeat (3) @(negedge clk);
    n_checks++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL reset_ack got=%b exp=0000", ack); end
    n_checks++; if (done !== 4'b0)    begin n_fail++; $display("FAIL reset_done got=%b exp=0000", done); end
    n_checks++; if (grant !== 4'b0)   begin n_fail++; $display("FAIL reset_grant got=%b exp=0000", grant); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    n_checks++; if (tmr_req !== 1'b0) begin n_fail++; $display("FAIL reset_tmr_req got=%b exp=0", tmr_req); end
    n_checks++; if (tmr_us !== 32'd0) begin n_fail++; $display("FAIL reset_tmr_us got=%0d exp=0", tmr_us); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
  endtask

  task automatic test_single();
    int cycles;
    wait_us[0*W +: W] = 32'd10;
    req = 4'b0001;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0001)  begin n_fail++; $display("FAIL single_grant got=%b exp=0001", grant); end
    n_checks++; if (tmr_us !== 32'd10)  begin n_fail++; $display("FAIL single_tmr_us got=%0d exp=10", tmr_us); end
    n_checks++; if (tmr_req !== 1'b1)   begin n_fail++; $display("FAIL single_tmr_req got=%b exp=1", tmr_req); end
    n_checks++; if (ack !== 4'b0001)    begin n_fail++; $display("FAIL single_ack got=%b exp=0001", ack); end
    req = '0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done === 4'b0 && cycles < 1000);
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL single_done got=%b exp=0001", done); end
    n_checks++; if (cycles < 500 || cycles > 502) begin n_fail++; $display("FAIL single_latency got=%0d exp=500..502", cycles); end
    @(negedge clk);
    n_checks++; if (grant !== 4'b0) begin n_fail++; $display("FAIL single_grant_clear got=%b exp=0000", grant); end
    n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL single_busy_clear got=%b exp=0", busy); end
  endtask

  task automatic test_round_robin();
    int n_ack, n_done, cycles;
    pulse_reset();
    obs_ack_q.delete();
    obs_done_q.delete();
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    for (int k = 0; k < N; k++) wait_us[k*W +: W] = 32'd2;
    req = 4'hF;
    n_ack = 0;
    n_done = 0;
    cycles = 0;
    while (n_done < 5 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (ack !== 4'b0) n_ack++;
      if (done !== 4'b0) n_done++;
      if (n_ack >= 5) req = '0;
    end
    @(negedge clk);
    n_checks++; if (n_done != 5) begin n_fail++; $display("FAIL rr_done_count got=%0d exp=5", n_done); end
    n_checks++; if (obs_ack_q.size() != 5) begin n_fail++; $display("FAIL rr_ack_q_size got=%0d exp=5", obs_ack_q.size()); end
    n_checks++; if (obs_done_q.size() != 5) begin n_fail++; $display("FAIL rr_done_q_size got=%0d exp=5", obs_done_q.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < obs_ack_q.size()) begin
        n_checks++; if (obs_ack_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_ack_order[%0d] got=%0d exp=%0d", i, obs_ack_q[i], exp_q[i]); end
      end
      if (i < obs_done_q.size()) begin
        n_checks++; if (obs_done_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rr_done_order[%0d] got=%0d exp=%0d", i, obs_done_q[i], exp_q[i]); end
      end
    end
  endtask

  task automatic test_zero_wait();
    tmr_req_seen = 1'b0;
    wait_us[2*W +: W] = 32'd0;
    req = 4'b0100;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL zero_ack got=%b exp=0100", ack); end
    n_checks++; if (done !== 4'b0)   begin n_fail++; $display("FAIL zero_done_early got=%b exp=0000", done); end
    req = '0;
    @(negedge clk);
    n_checks++; if (done !== 4'b0100) begin n_fail++; $display("FAIL zero_done got=%b exp=0100", done); end
    n_checks++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL zero_ack_clear got=%b exp=0000", ack); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0)         begin n_fail++; $display("FAIL zero_busy got=%b exp=0", busy); end
    n_checks++; if (tmr_req_seen !== 1'b0) begin n_fail++; $display("FAIL zero_tmr_req_seen got=%b exp=0", tmr_req_seen); end
  endtask

  task automatic test_reset_mid();
    logic stray_seen, bad_done;
    int cycles, cnt;
    wait_us[1*W +: W] = 32'd1;
    req = 4'b0010;
    @(negedge clk);
    n_checks++; if (ack !== 4'b0010) begin n_fail++; $display("FAIL rmid_ack got=%b exp=0010", ack); end
    req = '0;
    repeat (5) @(negedge clk);
    n_checks++; if (dbg_state !== WAIT) begin n_fail++; $display("FAIL rmid_in_wait got=%0d exp=%0d", dbg_state, WAIT); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0)   begin n_fail++; $display("FAIL rmid_grant got=%b exp=0000", grant); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    n_checks++; if (done !== 4'b0)    begin n_fail++; $display("FAIL rmid_done got=%b exp=0000", done); end
    n_checks++; if (tmr_us !== 32'd0) begin n_fail++; $display("FAIL rmid_tmr_us got=%0d exp=0", tmr_us); end
    rst = 1'b0;
    stray_seen = 1'b0;
    bad_done = 1'b0;
    cycles = 0;
    cnt = 0;
    while (cnt < 3 && cycles < 200) begin
      @(negedge clk);
      cycles++;
      if (done !== 4'b0) bad_done = 1'b1;
      if (m_done) stray_seen = 1'b1;
      if (stray_seen) cnt++;
    end
    n_checks++; if (stray_seen !== 1'b1) begin n_fail++; $display("FAIL rmid_stray_seen got=%b exp=1", stray_seen); end
    n_checks++; if (bad_done !== 1'b0)   begin n_fail++; $display("FAIL rmid_stray_done got=%b exp=0", bad_done); end
    wait_us[3*W +: W] = 32'd1;
    req = 4'b1000;
    @(negedge clk);
    n_checks++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL rmid_new_ack got=%b exp=1000", ack); end
    req = '0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (done === 4'b0 && cycles < 200);
    n_checks++; if (done !== 4'b1000) begin n_fail++; $display("FAIL rmid_new_done got=%b exp=1000", done); end
    @(negedge clk);
  endtask

  task automatic test_ack_done_same();
    tmr_mode = 1'b1;
    wait_us[0*W +: W] = 32'd5;
    req = 4'b0001;
    @(negedge clk);
    n_checks++; if (tmr_req !== 1'b1) begin n_fail++; $display("FAIL same_tmr_req got=%b exp=1", tmr_req); end
    n_checks++; if (ack !== 4'b0)     begin n_fail++; $display("FAIL same_ack_early got=%b exp=0000", ack); end
    t_ack = 1'b1;
    t_done = 1'b1;
    #1;
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL same_ack got=%b exp=0001", ack); end
    req = '0;
    @(negedge clk);
    t_ack = 1'b0;
    t_done = 1'b0;
    #1;
    n_checks++; if (done !== 4'b0001) begin n_fail++; $display("FAIL same_done got=%b exp=0001", done); end
    n_checks++; if (tmr_req !== 1'b0) begin n_fail++; $display("FAIL same_tmr_req_drop got=%b exp=0", tmr_req); end
    @(negedge clk);
    n_checks++; if (dbg_state !== IDLE) begin n_fail++; $display("FAIL same_idle got=%0d exp=%0d", dbg_state, IDLE); end
    n_checks++; if (done !== 4'b0)      begin n_fail++; $display("FAIL same_done_single got=%b exp=0000", done); end
    tmr_mode = 1'b0;
  endtask

`ifdef TMR_ARB_WDOG_EN
  task automatic test_watchdog();
    int k, cycles;
    tmr_mode = 1'b1;
    wait_us[1*W +: W] = 32'd3;
    wait_us[2*W +: W] = 32'd3;
    req = 4'b0110;
    @(negedge clk);
    n_checks++; if (grant !== 4'b0010) begin n_fail++; $display("FAIL wdog_grant got=%b exp=0010", grant); end
    t_ack = 1'b1;
    req = 4'b0100;
    @(negedge clk);
    t_ack = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (err !== 1'b1 && k < 300);
    n_checks++; if (k != 100)           begin n_fail++; $display("FAIL wdog_cycle got=%0d exp=100", k); end
    n_checks++; if (done !== 4'b0010)   begin n_fail++; $display("FAIL wdog_done got=%b exp=0010", done); end
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (grant !== 4'b0100 && cycles < 10);
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL wdog_next_grant got=%b exp=0100", grant); end
    n_checks++; if (err_cnt != 1)      begin n_fail++; $display("FAIL wdog_err_count got=%0d exp=1", err_cnt); end
    tmr_mode = 1'b0;
    pulse_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_zero_wait();
    test_reset_mid();
    test_ack_done_same();
`ifdef TMR_ARB_WDOG_EN
    test_watchdog();
`else
    n_checks++; if (err_cnt != 0) begin n_fail++; $display("FAIL err_never got=%0d exp=0", err_cnt); end
`endif
    n_checks++; if (multi_hot !== 1'b0) begin n_fail++; $display("FAIL onehot_outputs got=%b exp=0", multi_hot); end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
